// File: rtl/btn_debounce_irq_if.sv
// Button block bus: raw pins and CPU-side controls in, conditioned levels, press pulses,
// pending flags and the interrupt request out.
interface btn_debounce_irq_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btns_raw;
    logic [N_BTN-1:0] irq_mask;
    logic             clr_we;
    logic [N_BTN-1:0] clr_mask;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] pending;
    logic             int_btn;

    modport master (
        output btns_raw, irq_mask, clr_we, clr_mask,
        input  btn_state, btn_press, pending, int_btn
    );

    modport slave (
        input  btns_raw, irq_mask, clr_we, clr_mask,
        output btn_state, btn_press, pending, int_btn
    );
endinterface

// File: rtl/btn_debounce_irq.sv
// Per-button synchroniser, stable-interval debouncer, press detector, sticky pending flag and level IRQ.
// Raw edge to BTN_STATE: 2 + DEBOUNCE_CYC cycles. No backpressure. Optional macro: BTN_AUTOREPEAT_EN.
module btn_debounce_irq #(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    btn_debounce_irq_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);

    logic [N_BTN-1:0] w_raw_norm;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_state;
    logic [DB_W-1:0]  r_db_cnt [N_BTN];
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_press_next;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] w_clr;
    logic             r_int;

    // Normalise so that 1 always means pressed; the reset value 0 is then "released".
    assign w_raw_norm = (ACTIVE_LOW != 0) ? ~bus.btns_raw : bus.btns_raw;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_state <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw_norm;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_state[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the acceptance of a 0->1 change, so the pulse registers alongside BTN_STATE.
    always_comb begin
        w_rise = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rise[i] = r_sync2[i] & ~r_state[i] & (r_db_cnt[i] == DB_MAX);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_W = (REPEAT_CYC > 2) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYC - 1);

    logic [RP_W-1:0]  r_rep_cnt [N_BTN];
    logic [N_BTN-1:0] w_rep_fire;

    always_comb begin
        w_rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rep_fire[i] = r_state[i] & (r_rep_cnt[i] == RP_MAX);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!r_state[i] || w_rep_fire[i]) begin
                    r_rep_cnt[i] <= '0;
                end else begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press_next = w_rise | w_rep_fire;
`else
    assign w_press_next = w_rise;
`endif

    // A new press outranks a clear landing in the same cycle.
    assign w_clr = {N_BTN{bus.clr_we}} & bus.clr_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_press   <= '0;
            r_pending <= '0;
            r_int     <= 1'b0;
        end else begin
            r_press   <= w_press_next;
            r_pending <= r_press | (r_pending & ~w_clr);
            r_int     <= |(r_pending & bus.irq_mask);
        end
    end

    assign bus.btn_state = r_state;
    assign bus.btn_press = r_press;
    assign bus.pending   = r_pending;
    assign bus.int_btn   = r_int;

endmodule
